// File: rtl/cdb_broadcast_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_broadcast_arbiter
// Collects completions from NUM_FU functional units into small per-port
// FIFOs and broadcasts at most one per cycle on the common data bus,
// selecting among non-empty FIFO heads round-robin.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : asynchronous active-low reset
//   fu_valid   : per-port completion request
//   fu_tag     : per-port PRF tag, port i at [i*TAG_W +: TAG_W]
//   fu_data    : per-port result, port i at [i*DATA_W +: DATA_W]
//   fu_ready   : per-port accept (FIFO not full, from registered count)
//   cdb_valid  : registered broadcast valid
//   cdb_tag    : registered broadcast tag
//   cdb_data   : registered broadcast data
//   cdb_src    : registered index of the granted port
// ---------------------------------------------------------------------------
module cdb_broadcast_arbiter #(
    parameter int unsigned NUM_FU     = 3,
    parameter int unsigned TAG_W      = 6,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_FU-1:0]          fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
    input  logic [NUM_FU*DATA_W-1:0]   fu_data,
    output logic [NUM_FU-1:0]          fu_ready,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [1:0]                 cdb_src
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned SRC_W = 2;

    // Per-port storage and bookkeeping
    logic [TAG_W-1:0]  r_tag_mem  [NUM_FU][FIFO_DEPTH];
    logic [DATA_W-1:0] r_data_mem [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr   [NUM_FU];
    logic [PTR_W-1:0]  r_rd_ptr   [NUM_FU];
    logic [CNT_W-1:0]  r_cnt      [NUM_FU];
    logic [RR_W-1:0]   r_rr_ptr;

    logic [NUM_FU-1:0] w_push;
    logic [NUM_FU-1:0] w_pop;
    logic [NUM_FU-1:0] w_nonempty;
    logic              w_grant_vld;
    logic [RR_W-1:0]   w_grant_idx;
    logic [TAG_W-1:0]  w_head_tag;
    logic [DATA_W-1:0] w_head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [RR_W-1:0] rr_inc(input logic [RR_W-1:0] p);
        return (p == RR_W'(NUM_FU - 1)) ? '0 : p + RR_W'(1);
    endfunction

    // Accept and occupancy: ready looks only at the registered count
    always_comb begin
        w_nonempty = '0;
        fu_ready   = '0;
        w_push     = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_nonempty[i] = (r_cnt[i] != '0);
            fu_ready[i]   = (r_cnt[i] < CNT_W'(FIFO_DEPTH));
            w_push[i]     = fu_valid[i] & fu_ready[i];
        end
    end

    // Round-robin pick: first non-empty head at or after r_rr_ptr, wrapping
    always_comb begin
        logic [RR_W:0]   sum;
        logic [RR_W-1:0] idx;
        sum         = '0;
        idx         = '0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_pop       = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, r_rr_ptr} + (RR_W + 1)'(k);
            if (sum >= (RR_W + 1)'(NUM_FU)) begin
                sum = sum - (RR_W + 1)'(NUM_FU);
            end
            idx = sum[RR_W-1:0];
            if (!w_grant_vld && w_nonempty[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = idx;
            end
        end
        if (w_grant_vld) begin
            w_pop[w_grant_idx] = 1'b1;
        end
        w_head_tag  = r_tag_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];
        w_head_data = r_data_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];
    end

    // FIFO payload storage; contents are never observed unless counted valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_push[i]) begin
                r_tag_mem[i][r_wr_ptr[i]]  <= fu_tag[i*TAG_W +: TAG_W];
                r_data_mem[i][r_wr_ptr[i]] <= fu_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointers, counts, round-robin pointer and registered broadcast
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_cnt[i]    <= '0;
            end
            r_rr_ptr  <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= ptr_inc(r_wr_ptr[i]);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= ptr_inc(r_rd_ptr[i]);
                end
                // Push and pop together leave the count unchanged
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
            if (w_grant_vld) begin
                r_rr_ptr  <= rr_inc(w_grant_idx);
                cdb_valid <= 1'b1;
                cdb_tag   <= w_head_tag;
                cdb_data  <= w_head_data;
                cdb_src   <= SRC_W'(w_grant_idx);
            end else begin
                cdb_valid <= 1'b0;
                cdb_tag   <= '0;
                cdb_data  <= '0;
                cdb_src   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_broadcast_arbiter
// Directed scenarios with hand-computed per-edge expectations for the
// broadcast bus and for fu_ready ahead of each edge.
// ---------------------------------------------------------------------------
module tb_cdb_broadcast_arbiter;

    localparam int unsigned NUM_FU = 3;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MAXE   = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]        fu_ready;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic [1:0]               cdb_src;

    int n_cmp = 0;
    int n_err = 0;

    // Scenario configuration and expectation tables (edge index 1..n)
    int         max_cyc [NUM_FU];
    int         max_acc [NUM_FU];
    logic [5:0] tbase   [NUM_FU];
    int         acc     [NUM_FU];
    logic [5:0] exp_tag [MAXE];
    logic [1:0] exp_src [MAXE];
    logic [2:0] exp_rdy [MAXE];

    cdb_broadcast_arbiter #(
        .NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data),
        .fu_ready(fu_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // Data payload is a fixed function of the tag
    function automatic logic [31:0] td(input logic [5:0] t);
        return (t == 6'h0A) ? 32'h0000_1234 : {16'hC0DE, 10'h0, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int p, input int mc, input int ma, input logic [5:0] b);
        max_cyc[p] = mc;
        max_acc[p] = ma;
        tbase[p]   = b;
    endtask

    task automatic ex(input int e, input logic [5:0] t, input logic [1:0] s, input logic [2:0] r);
        exp_tag[e] = t;
        exp_src[e] = s;
        exp_rdy[e] = r;
    endtask

    task automatic clr();
        for (int i = 0; i < NUM_FU; i++) cfg(i, 0, 0, 6'h0);
        for (int e = 0; e < MAXE; e++) ex(e, 6'h0, 2'd0, 3'b111);
    endtask

    task automatic check_cdb(input string nm, input logic [5:0] t, input logic [1:0] s);
        check({nm, " vld"},  64'(cdb_valid), 64'(t != 6'h0));
        check({nm, " tag"},  64'(cdb_tag),   64'(t));
        check({nm, " data"}, 64'(cdb_data),  (t == 6'h0) ? 64'h0 : 64'(td(t)));
        check({nm, " src"},  64'(cdb_src),   64'(s));
    endtask

    task automatic do_reset();
        fu_valid = '0;
        reset    = 1'b0;
        tick();
        tick();
        reset    = 1'b1;
    endtask

    // Handshaking producers drive each port; the tables give the bus and ready
    task automatic run(input string nm, input int n);
        logic [NUM_FU-1:0] vld;
        logic [NUM_FU-1:0] rdy;
        logic [5:0]        t;
        for (int i = 0; i < NUM_FU; i++) acc[i] = 0;
        for (int e = 1; e <= n; e++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                vld[i] = (e <= max_cyc[i]) && (acc[i] < max_acc[i]);
                t      = tbase[i] + 6'(acc[i]);
                fu_valid[i]                  = vld[i];
                fu_tag[i*TAG_W +: TAG_W]     = vld[i] ? t : 6'h0;
                fu_data[i*DATA_W +: DATA_W]  = vld[i] ? td(t) : 32'h0;
            end
            #1;
            rdy = fu_ready;
            check($sformatf("%s rdy e%0d", nm, e), 64'(fu_ready), 64'(exp_rdy[e]));
            tick();
            for (int i = 0; i < NUM_FU; i++) begin
                if (vld[i] && rdy[i]) acc[i]++;
            end
            check_cdb($sformatf("%s e%0d", nm, e), exp_tag[e], exp_src[e]);
        end
        fu_valid = '0;
    endtask

    initial begin
        reset    = 1'b1;
        fu_valid = '0;
        fu_tag   = '0;
        fu_data  = '0;

        // Asynchronous reset before any clock edge, then transfers ignored in reset
        #1 reset = 1'b0;
        #1;
        check_cdb("rst async", 6'h0, 2'd0);
        check("rst rdy", 64'(fu_ready), 64'h7);
        fu_valid = 3'b111;
        fu_tag   = {6'h23, 6'h13, 6'h03};
        fu_data  = {32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC};
        tick();
        tick();
        check("rst hold rdy", 64'(fu_ready), 64'h7);
        check_cdb("rst hold", 6'h0, 2'd0);
        fu_valid = '0;
        reset    = 1'b1;
        tick();
        check_cdb("post rst e1", 6'h0, 2'd0);
        tick();
        check_cdb("post rst e2", 6'h0, 2'd0);

        // Single completion on port 1
        do_reset();
        clr();
        cfg(1, 1, 1, 6'h0A);
        ex(2, 6'h0A, 2'd1, 3'b111);
        run("single", 3);

        // Three-way contention straight after reset
        do_reset();
        clr();
        cfg(0, 1, 1, 6'h01); cfg(1, 1, 1, 6'h02); cfg(2, 1, 1, 6'h03);
        ex(2, 6'h01, 2'd0, 3'b111);
        ex(3, 6'h02, 2'd1, 3'b111);
        ex(4, 6'h03, 2'd2, 3'b111);
        run("contend", 5);

        // Fairness: ports 0 and 2 request for 8 cycles
        do_reset();
        clr();
        cfg(0, 8, 99, 6'h01); cfg(2, 8, 99, 6'h21);
        ex(2,  6'h01, 2'd0, 3'b111);
        ex(3,  6'h21, 2'd2, 3'b011);
        ex(4,  6'h02, 2'd0, 3'b110);
        ex(5,  6'h22, 2'd2, 3'b011);
        ex(6,  6'h03, 2'd0, 3'b110);
        ex(7,  6'h23, 2'd2, 3'b011);
        ex(8,  6'h04, 2'd0, 3'b110);
        ex(9,  6'h24, 2'd2, 3'b011);
        ex(10, 6'h05, 2'd0, 3'b111);
        ex(11, 6'h25, 2'd2, 3'b111);
        run("fair", 12);
        check("fair acc0", 64'(acc[0]), 64'd5);
        check("fair acc2", 64'(acc[2]), 64'd5);

        // Backpressure on port 0 while ports 1 and 2 stay busy
        do_reset();
        clr();
        cfg(0, 99, 4, 6'h01); cfg(1, 6, 99, 6'h11); cfg(2, 6, 99, 6'h21);
        ex(2,  6'h01, 2'd0, 3'b111);
        ex(3,  6'h11, 2'd1, 3'b001);
        ex(4,  6'h21, 2'd2, 3'b010);
        ex(5,  6'h02, 2'd0, 3'b100);
        ex(6,  6'h12, 2'd1, 3'b001);
        ex(7,  6'h22, 2'd2, 3'b010);
        ex(8,  6'h03, 2'd0, 3'b110);
        ex(9,  6'h13, 2'd1, 3'b111);
        ex(10, 6'h23, 2'd2, 3'b111);
        ex(11, 6'h04, 2'd0, 3'b111);
        run("bp", 12);
        check("bp acc0", 64'(acc[0]), 64'd4);
        check("bp acc1", 64'(acc[1]), 64'd3);
        check("bp acc2", 64'(acc[2]), 64'd3);

        // Push and pop on port 0 in the same cycle keeps count at 1
        do_reset();
        clr();
        cfg(0, 2, 99, 6'h05);
        ex(2, 6'h05, 2'd0, 3'b111);
        ex(3, 6'h06, 2'd0, 3'b111);
        run("pushpop", 4);

        // Reset mid-flight with two entries buffered on port 2
        do_reset();
        fu_valid = 3'b101;
        fu_tag   = {6'h21, 6'h00, 6'h01};
        fu_data  = {td(6'h21), 32'h0, td(6'h01)};
        tick();
        fu_valid = 3'b100;
        fu_tag   = {6'h22, 6'h00, 6'h00};
        fu_data  = {td(6'h22), 32'h0, 32'h0};
        tick();
        fu_valid = '0;
        check_cdb("mid pre", 6'h01, 2'd0);
        check("mid pre rdy", 64'(fu_ready), 64'h3);
        #2 reset = 1'b0;
        #1;
        check_cdb("mid async", 6'h0, 2'd0);
        check("mid rst rdy", 64'(fu_ready), 64'h7);
        tick();
        #2 reset = 1'b1;
        tick();
        check_cdb("mid post e1", 6'h0, 2'd0);
        tick();
        check_cdb("mid post e2", 6'h0, 2'd0);
        tick();
        check_cdb("mid post e3", 6'h0, 2'd0);
        // Round-robin restarts at port 0
        clr();
        cfg(0, 1, 1, 6'h31); cfg(1, 1, 1, 6'h32); cfg(2, 1, 1, 6'h33);
        ex(2, 6'h31, 2'd0, 3'b111);
        ex(3, 6'h32, 2'd1, 3'b111);
        ex(4, 6'h33, 2'd2, 3'b111);
        run("mid rr", 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_broadcast_arbiter.md
CDB_BROADCAST_ARBITER -- requirements
Module: cdb_broadcast_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide NUM_FU, 3, number of functional-unit completion ports.
REQ-002 SHALL provide TAG_W, 6, PRF tag width.
REQ-003 SHALL provide DATA_W, 32, result data width.
REQ-004 SHALL provide FIFO_DEPTH, 2, completion buffer entries per port (power of 2).
Ports (name, direction, width, meaning):
REQ-005 SHALL provide clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL provide reset, input, 1; one clock; reset is asynchronous and active-low.
REQ-007 SHALL provide fu_valid, input, NUM_FU, per-port completion request.
REQ-008 SHALL provide fu_tag, input, NUM_FU*TAG_W, destination PRF tags; port i in bits [i*TAG_W +: TAG_W].
REQ-009 SHALL provide fu_data, input, NUM_FU*DATA_W, results; port i in bits [i*DATA_W +: DATA_W].
REQ-010 SHALL provide fu_ready, output, NUM_FU, per-port accept.
REQ-011 SHALL provide cdb_valid, output, 1, broadcast valid, consumed by wakeup logic.
REQ-012 SHALL provide cdb_tag, output, TAG_W, broadcast PRF tag.
REQ-013 SHALL provide cdb_data, output, DATA_W, broadcast result.
REQ-014 SHALL provide cdb_src, output, 2, index of the granted port.

Function
REQ-015 Port i transfer SHALL occur on a rising edge where fu_valid[i] and fu_ready[i] are both 1; tag/data are written to port i's FIFO tail.
REQ-016 fu_ready[i] SHALL be 1 iff port i's FIFO count < FIFO_DEPTH, from registered count only (no same-cycle pop bypass).
REQ-017 fu_valid high while fu_ready low SHALL cause no write and no state change; the producer holds its tag/data.
REQ-018 Each cycle, arbitration SHALL select at most one non-empty FIFO head, round-robin: search starts at rr_ptr, wraps modulo NUM_FU.
REQ-019 On a grant to port g, that head SHALL be popped, and rr_ptr SHALL become (g+1) mod NUM_FU on the same edge; with no grant, rr_ptr SHALL hold.
REQ-020 Granted entry SHALL be registered: cdb_valid=1, cdb_tag/cdb_data/cdb_src = head fields, visible for exactly one cycle after the grant edge.
REQ-021 With no grant, cdb_valid, cdb_tag, cdb_data and cdb_src SHALL all be 0 in the following cycle.
REQ-022 Latency SHALL be: entry written at edge N into an empty FIFO, with the arbiter granting it, appears on the CDB after edge N+1.
REQ-023 Simultaneous push and pop on one FIFO SHALL leave its count unchanged and preserve FIFO order.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-025 Entries from one port SHALL broadcast in acceptance order; no entry SHALL be dropped or duplicated.
REQ-026 Sustained throughput SHALL be one broadcast per cycle whenever any FIFO is non-empty.

Reset
REQ-027 Asserting reset low SHALL immediately, without waiting for clk, clear all FIFO counts/pointers, set rr_ptr=0, and drive cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0.
REQ-028 While reset is low, fu_ready SHALL be all-ones (all FIFOs empty), and no transfer SHALL be recorded.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries; the first edge after deassertion SHALL behave as post-reset.

Verification
REQ-030 Single: port 1 pushes tag=0x0A, data=0x1234 at edge N, idle otherwise -> after edge N+1: cdb_valid=1, tag=0x0A, data=0x1234, src=1, then cdb_valid=0.
REQ-031 Contention: all three ports push simultaneously (tags 0x01,0x02,0x03) after reset -> broadcasts in consecutive cycles, src order 0,1,2, then cdb_valid=0.
REQ-032 Fairness: ports 0 and 2 push every cycle for 8 cycles -> grants alternate 0,2,0,2...; neither port starved; every accepted tag appears exactly once, in order per port.
REQ-033 Backpressure: port 0 pushes 4 entries on consecutive cycles while ports 1 and 2 each keep a non-empty FIFO -> fu_ready[0]=0 once count hits 2; held entries accepted later; all 4 tags broadcast in order.
REQ-034 Reset mid-flight: two entries buffered on port 2, reset driven low between edges -> cdb_valid=0 asynchronously; after release no stale tag is broadcast; rr_ptr=0.
REQ-035 Push/pop same cycle: port 0 count=1, new push at the same edge as a pop -> count stays 1; next broadcast carries the new tag.
